// File: rtl/keyscan_pkg.sv
// Shared state encoding and default parameter values for the key matrix scanner.
package keyscan_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld,
        StRelease
    } scan_state_e;

    localparam int unsigned DefNumRows        = 4;
    localparam int unsigned DefNumCols        = 4;
    localparam int unsigned DefScanDiv        = 4;
    localparam int unsigned DefDebounceCycles = 8;
    localparam int unsigned DefRepeatCycles   = 0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; reset is synchronous, active-low.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_matrix_scan.sv
// Row-scanning keypad controller: one-hot row drive, single-key debounce, optional auto-repeat
// and multi-key detection. All outputs come straight from flops.
module key_matrix_scan
    import keyscan_pkg::*;
#(
    parameter int unsigned NUM_ROWS        = DefNumRows,
    parameter int unsigned NUM_COLS        = DefNumCols,
    parameter int unsigned SCAN_DIV        = DefScanDiv,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned REPEAT_CYCLES   = DefRepeatCycles
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_COLS-1:0]                 cols,
    output logic [NUM_ROWS-1:0]                 rows,
    output logic                                keyValid,
    output logic [$clog2(NUM_ROWS*NUM_COLS)-1:0] keyCode,
    output logic                                keyHeld,
    output logic                                multiKey
);

    localparam int unsigned RowW   = $clog2(NUM_ROWS);
    localparam int unsigned ColW   = $clog2(NUM_COLS);
    localparam int unsigned CodeW  = $clog2(NUM_ROWS * NUM_COLS);
    localparam int unsigned DwellW = $clog2(SCAN_DIV);
    localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RepW   = $clog2(REPEAT_CYCLES + 2);

    logic [NUM_COLS-1:0] cols_sync;

    scan_state_e         state_q, state_d;
    logic [RowW-1:0]     row_q, row_d;
    logic [ColW-1:0]     col_q, col_d;
    logic [DwellW-1:0]   dwell_q, dwell_d;
    logic [DebW-1:0]     deb_q, deb_d;
    logic [RepW-1:0]     rep_q, rep_d;
    logic [NUM_ROWS-1:0] rows_q, rows_d;
    logic                key_valid_q, key_valid_d;
    logic [CodeW-1:0]    key_code_q, key_code_d;
    logic                key_held_q, key_held_d;
    logic                multi_key_q, multi_key_d;

    int unsigned         n_high;
    logic [ColW-1:0]     hit_col;
    logic [RowW-1:0]     row_next;
    logic                col_on;

    sync_2ff #(
        .Width (NUM_COLS)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (cols),
        .q_o    (cols_sync)
    );

    // Column population count; hit_col is only meaningful when exactly one column is high.
    always_comb begin
        n_high  = 0;
        hit_col = '0;
        for (int i = 0; i < int'(NUM_COLS); i++) begin
            if (cols_sync[i]) begin
                n_high  = n_high + 1;
                hit_col = ColW'(i);
            end
        end
    end

    assign row_next = (row_q == RowW'(NUM_ROWS - 1)) ? '0 : row_q + RowW'(1);
    assign col_on   = cols_sync[col_q];

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        rep_d       = rep_q;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        key_valid_d = 1'b0;
        multi_key_d = 1'b0;

        unique case (state_q)
            StScan: begin
                if (dwell_q == DwellW'(SCAN_DIV - 1)) begin
                    dwell_d = '0;
                    if (n_high == 1) begin
                        col_d   = hit_col;
                        deb_d   = '0;
                        state_d = StDebounce;
                    end else begin
                        row_d       = row_next;
                        multi_key_d = (n_high > 1);
                    end
                end else begin
                    dwell_d = dwell_q + DwellW'(1);
                end
            end
            StDebounce: begin
                if (!col_on) begin
                    state_d = StScan;
                    row_d   = row_next;
                    dwell_d = '0;
                end else if (deb_q == DebW'(DEBOUNCE_CYCLES - 1)) begin
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    key_code_d  = CodeW'(row_q * NUM_COLS + col_q);
                    rep_d       = '0;
                    state_d     = StHeld;
                end else begin
                    deb_d = deb_q + DebW'(1);
                end
            end
            StHeld: begin
                if (!col_on) begin
                    deb_d   = '0;
                    state_d = StRelease;
                end else if (REPEAT_CYCLES > 0) begin
                    if (rep_q == RepW'(REPEAT_CYCLES - 1)) begin
                        key_valid_d = 1'b1;
                        rep_d       = '0;
                    end else begin
                        rep_d = rep_q + RepW'(1);
                    end
                end
            end
            StRelease: begin
                if (col_on) begin
                    rep_d   = '0;
                    state_d = StHeld;
                end else if (deb_q == DebW'(DEBOUNCE_CYCLES - 1)) begin
                    key_held_d = 1'b0;
                    row_d      = row_next;
                    dwell_d    = '0;
                    state_d    = StScan;
                end else begin
                    deb_d = deb_q + DebW'(1);
                end
            end
            default: state_d = StScan;
        endcase

        // Row drive is registered from the next row index so it tracks rowIdx without lag.
        rows_d        = '0;
        rows_d[row_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StScan;
            row_q       <= '0;
            col_q       <= '0;
            dwell_q     <= '0;
            deb_q       <= '0;
            rep_q       <= '0;
            rows_q      <= {{(NUM_ROWS - 1){1'b0}}, 1'b1};
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
            multi_key_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            rep_q       <= rep_d;
            rows_q      <= rows_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            multi_key_q <= multi_key_d;
        end
    end

    assign rows     = rows_q;
    assign keyValid = key_valid_q;
    assign keyCode  = key_code_q;
    assign keyHeld  = key_held_q;
    assign multiKey = multi_key_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan: a default instance plus one with auto-repeat enabled.
module tb_key_matrix_scan;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cols, rows, cols_r, rows_r;
    logic       kv, kh, mk, kv_r, kh_r, mk_r;
    logic [3:0] code, code_r;

    logic       key_on = 1'b0;
    logic       keyr_on = 1'b0;
    logic [1:0] key_row = 2'd0;
    logic [1:0] key_col = 2'd0;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'b0000;

    int checks = 0;
    int passed = 0;
    int kv_cnt = 0;
    int mk_cnt = 0;
    int kvr_cnt = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    // A pressed key connects its column to its row only while that row is driven.
    assign cols   = force_en ? force_val :
                    ((key_on && rows[key_row]) ? (4'b0001 << key_col) : 4'b0000);
    assign cols_r = (keyr_on && rows_r[3]) ? 4'b1000 : 4'b0000;

    key_matrix_scan dut (
        .clk      (clk),
        .reset    (reset),
        .cols     (cols),
        .rows     (rows),
        .keyValid (kv),
        .keyCode  (code),
        .keyHeld  (kh),
        .multiKey (mk)
    );

    key_matrix_scan #(
        .REPEAT_CYCLES (20)
    ) dut_rep (
        .clk      (clk),
        .reset    (reset),
        .cols     (cols_r),
        .rows     (rows_r),
        .keyValid (kv_r),
        .keyCode  (code_r),
        .keyHeld  (kh_r),
        .multiKey (mk_r)
    );

    always @(posedge clk) begin
        if (kv) kv_cnt <= kv_cnt + 1;
        if (mk) mk_cnt <= mk_cnt + 1;
        if (kv_r) kvr_cnt <= kvr_cnt + 1;
        if ((kv && mk) || (kv_r && mk_r)) both_cnt <= both_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Two reset edges, then release at a falling edge; the next rising edge is scan cycle 1.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        checks++; if (rows !== 4'b0001) $display("FAIL reset_rows: got %b want 0001", rows); else passed++;
        checks++; if (kv !== 1'b0) $display("FAIL reset_valid: got %b want 0", kv); else passed++;
        checks++; if (code !== 4'd0) $display("FAIL reset_code: got %0d want 0", code); else passed++;
        checks++; if (kh !== 1'b0) $display("FAIL reset_held: got %b want 0", kh); else passed++;
        checks++; if (mk !== 1'b0) $display("FAIL reset_multi: got %b want 0", mk); else passed++;
        checks++; if (rows_r !== 4'b0001) $display("FAIL reset_rows_rep: got %b want 0001", rows_r); else passed++;
    endtask

    task automatic test_press();
        int base;
        force_en = 1'b0; key_row = 2'd2; key_col = 2'd1; key_on = 1'b1;
        do_reset();
        base = kv_cnt;
        tick(19);
        checks++; if (kv !== 1'b0) $display("FAIL press_early_valid: got %b want 0", kv); else passed++;
        checks++; if (kh !== 1'b0) $display("FAIL press_early_held: got %b want 0", kh); else passed++;
        tick(1);
        checks++; if (kv !== 1'b1) $display("FAIL press_valid: got %b want 1", kv); else passed++;
        checks++; if (code !== 4'd9) $display("FAIL press_code: got %0d want 9", code); else passed++;
        checks++; if (kh !== 1'b1) $display("FAIL press_held: got %b want 1", kh); else passed++;
        tick(1);
        checks++; if (kv !== 1'b0) $display("FAIL press_valid_width: got %b want 0", kv); else passed++;
        tick(48);
        checks++; if (kv_cnt - base !== 1) $display("FAIL press_valid_count: got %0d want 1", kv_cnt - base); else passed++;
        checks++; if (rows !== 4'b0100) $display("FAIL press_rows_frozen: got %b want 0100", rows); else passed++;
        key_on = 1'b0;
        tick(10);
        checks++; if (kh !== 1'b1) $display("FAIL press_held_before_release: got %b want 1", kh); else passed++;
        tick(1);
        checks++; if (kh !== 1'b0) $display("FAIL press_held_after_release: got %b want 0", kh); else passed++;
        checks++; if (rows !== 4'b1000) $display("FAIL press_next_row: got %b want 1000", rows); else passed++;
    endtask

    task automatic test_debounce_abort();
        int base;
        key_on = 1'b0; force_en = 1'b1; force_val = 4'b0000;
        do_reset();
        base = kv_cnt;
        force_val = 4'b0001;
        tick(5);
        force_val = 4'b0000;
        tick(2);
        checks++; if (rows !== 4'b0001) $display("FAIL abort_rows_frozen: got %b want 0001", rows); else passed++;
        tick(1);
        checks++; if (rows !== 4'b0010) $display("FAIL abort_resume_row1: got %b want 0010", rows); else passed++;
        tick(4);
        checks++; if (rows !== 4'b0100) $display("FAIL abort_scan_row2: got %b want 0100", rows); else passed++;
        tick(20);
        checks++; if (kv_cnt - base !== 0) $display("FAIL abort_valid_count: got %0d want 0", kv_cnt - base); else passed++;
        checks++; if (kh !== 1'b0) $display("FAIL abort_held: got %b want 0", kh); else passed++;
        force_en = 1'b0;
    endtask

    task automatic test_multikey();
        int base_mk;
        int base_kv;
        key_on = 1'b0; force_en = 1'b1; force_val = 4'b1010;
        do_reset();
        base_mk = mk_cnt;
        base_kv = kv_cnt;
        tick(3);
        checks++; if (mk !== 1'b0) $display("FAIL multi_before_sample: got %b want 0", mk); else passed++;
        tick(1);
        checks++; if (mk !== 1'b1) $display("FAIL multi_pulse_row0: got %b want 1", mk); else passed++;
        checks++; if (rows !== 4'b0010) $display("FAIL multi_rows_1: got %b want 0010", rows); else passed++;
        tick(1);
        checks++; if (mk !== 1'b0) $display("FAIL multi_pulse_width: got %b want 0", mk); else passed++;
        tick(3);
        checks++; if (rows !== 4'b0100 || mk !== 1'b1) $display("FAIL multi_row2: got rows=%b mk=%b want 0100/1", rows, mk); else passed++;
        tick(4);
        checks++; if (rows !== 4'b1000 || mk !== 1'b1) $display("FAIL multi_row3: got rows=%b mk=%b want 1000/1", rows, mk); else passed++;
        tick(4);
        checks++; if (rows !== 4'b0001 || mk !== 1'b1) $display("FAIL multi_wrap: got rows=%b mk=%b want 0001/1", rows, mk); else passed++;
        tick(1);
        checks++; if (mk_cnt - base_mk !== 4) $display("FAIL multi_count: got %0d want 4", mk_cnt - base_mk); else passed++;
        checks++; if (kv_cnt - base_kv !== 0) $display("FAIL multi_no_valid: got %0d want 0", kv_cnt - base_kv); else passed++;
        force_en = 1'b0;
    endtask

    task automatic test_release_glitch();
        int base;
        force_en = 1'b0; key_row = 2'd2; key_col = 2'd1; key_on = 1'b1;
        do_reset();
        base = kv_cnt;
        tick(20);
        checks++; if (kh !== 1'b1) $display("FAIL glitch_held_start: got %b want 1", kh); else passed++;
        tick(2);
        key_on = 1'b0;
        tick(5);
        key_on = 1'b1;
        checks++; if (kh !== 1'b1) $display("FAIL glitch_held_mid: got %b want 1", kh); else passed++;
        tick(5);
        checks++; if (kh !== 1'b1) $display("FAIL glitch_held_back: got %b want 1", kh); else passed++;
        tick(30);
        checks++; if (kh !== 1'b1) $display("FAIL glitch_held_late: got %b want 1", kh); else passed++;
        checks++; if (kv_cnt - base !== 1) $display("FAIL glitch_valid_count: got %0d want 1", kv_cnt - base); else passed++;
        checks++; if (rows !== 4'b0100) $display("FAIL glitch_rows: got %b want 0100", rows); else passed++;
        key_on = 1'b0;
        tick(10);
        checks++; if (kh !== 1'b1) $display("FAIL glitch_release_early: got %b want 1", kh); else passed++;
        tick(1);
        checks++; if (kh !== 1'b0) $display("FAIL glitch_release_done: got %b want 0", kh); else passed++;
    endtask

    task automatic test_reset_mid_held();
        int base;
        force_en = 1'b0; key_row = 2'd2; key_col = 2'd1; key_on = 1'b1;
        do_reset();
        tick(20);
        checks++; if (kv !== 1'b1) $display("FAIL midrst_first_valid: got %b want 1", kv); else passed++;
        tick(5);
        reset = 1'b0;
        tick(1);
        checks++; if (rows !== 4'b0001) $display("FAIL midrst_rows: got %b want 0001", rows); else passed++;
        checks++; if (kh !== 1'b0) $display("FAIL midrst_held: got %b want 0", kh); else passed++;
        checks++; if (code !== 4'd0) $display("FAIL midrst_code: got %0d want 0", code); else passed++;
        reset = 1'b1;
        base = kv_cnt;
        tick(19);
        checks++; if (kv_cnt - base !== 0) $display("FAIL midrst_no_pending: got %0d want 0", kv_cnt - base); else passed++;
        checks++; if (kv !== 1'b0) $display("FAIL midrst_early_valid: got %b want 0", kv); else passed++;
        tick(1);
        checks++; if (kv !== 1'b1 || code !== 4'd9) $display("FAIL midrst_reaccept: got kv=%b code=%0d want 1/9", kv, code); else passed++;
        key_on = 1'b0;
        tick(15);
    endtask

    task automatic test_repeat();
        int base;
        key_on = 1'b0; force_en = 1'b0; keyr_on = 1'b1;
        do_reset();
        base = kvr_cnt;
        tick(24);
        checks++; if (kv_r !== 1'b1) $display("FAIL repeat_accept: got %b want 1", kv_r); else passed++;
        checks++; if (code_r !== 4'd15) $display("FAIL repeat_accept_code: got %0d want 15", code_r); else passed++;
        checks++; if (kh_r !== 1'b1) $display("FAIL repeat_held: got %b want 1", kh_r); else passed++;
        tick(1);
        checks++; if (kv_r !== 1'b0) $display("FAIL repeat_pulse_width: got %b want 0", kv_r); else passed++;
        tick(19);
        checks++; if (kv_r !== 1'b1 || code_r !== 4'd15) $display("FAIL repeat_1: got kv=%b code=%0d want 1/15", kv_r, code_r); else passed++;
        for (int k = 2; k <= 5; k++) begin
            tick(19);
            checks++; if (kv_r !== 1'b0) $display("FAIL repeat_gap_%0d: got %b want 0", k, kv_r); else passed++;
            tick(1);
            checks++; if (kv_r !== 1'b1 || code_r !== 4'd15) $display("FAIL repeat_%0d: got kv=%b code=%0d want 1/15", k, kv_r, code_r); else passed++;
        end
        keyr_on = 1'b0;
        tick(1);
        checks++; if (kvr_cnt - base !== 6) $display("FAIL repeat_count: got %0d want 6", kvr_cnt - base); else passed++;
        tick(9);
        checks++; if (kh_r !== 1'b1) $display("FAIL repeat_release_early: got %b want 1", kh_r); else passed++;
        tick(1);
        checks++; if (kh_r !== 1'b0) $display("FAIL repeat_release_done: got %b want 0", kh_r); else passed++;
        checks++; if (kvr_cnt - base !== 6) $display("FAIL repeat_count_after: got %0d want 6", kvr_cnt - base); else passed++;
    endtask

    initial begin
        test_reset();
        test_press();
        test_debounce_abort();
        test_multikey();
        test_release_glitch();
        test_reset_mid_held();
        test_repeat();
        checks++; if (both_cnt !== 0) $display("FAIL valid_multi_overlap: got %0d want 0", both_cnt); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/key_matrix_scan.md
KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

Interface
REQ-001 Parameter NUM_ROWS, default 4, number of driven rows (range 2..16).
REQ-002 Parameter NUM_COLS, default 4, number of sensed columns (range 2..16).
REQ-003 Parameter SCAN_DIV, default 4, dwell cycles per row (>=3).
REQ-004 Parameter DEBOUNCE_CYCLES, default 8, stable cycles required for press and release (>=1).
REQ-005 Parameter REPEAT_CYCLES, default 0, auto-repeat interval in cycles; 0 disables repeat.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 cols  input  NUM_COLS  asynchronous column sense lines, active-high.
REQ-009 rows  output  NUM_ROWS  one-hot row drive, active-high.
REQ-010 keyValid  output  1  one-cycle pulse per accepted press or repeat.
REQ-011 keyCode  output  $clog2(NUM_ROWS*NUM_COLS)  row*NUM_COLS+col of the last accepted key; holds between pulses.
REQ-012 keyHeld  output  1  high from the first keyValid until release debounce completes.
REQ-013 multiKey  output  1  one-cycle pulse when more than one column is high at a sample point.

Function
REQ-014 cols SHALL pass through a 2-flop synchroniser; "cols" below means the synchronised value.
REQ-015 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-016 SCAN: rows one-hot on rowIdx; dwell counter counts 0..SCAN_DIV-1; cols sampled only at count SCAN_DIV-1.
REQ-017 SCAN sample with no column high: rowIdx advances, wrapping NUM_ROWS-1 -> 0, dwell counter resets.
REQ-018 SCAN sample with exactly one column high: latch rowIdx and the column index, clear debounce counter, enter DEBOUNCE, freeze rows.
REQ-019 SCAN sample with >=2 columns high: pulse multiKey, latch nothing, advance row as in REQ-017.
REQ-020 DEBOUNCE: counter increments each cycle the latched column is high; if the latched column goes low, return to SCAN at the next row with no keyValid.
REQ-021 DEBOUNCE: when the counter reaches DEBOUNCE_CYCLES, keyCode updates, keyValid pulses for exactly one cycle and keyHeld rises in that same cycle, and the FSM enters HELD.
REQ-022 HELD: rows stay frozen; other columns and other rows are ignored; latched column low enters RELEASE with counter cleared.
REQ-023 HELD with REPEAT_CYCLES>0: keyValid re-pulses, with keyCode unchanged, every REPEAT_CYCLES cycles spent continuously in HELD; the repeat counter clears on entry to HELD.
REQ-024 RELEASE: counter increments each cycle the latched column is low; if the column goes high, return to HELD with the repeat counter cleared and no keyValid.
REQ-025 RELEASE: at DEBOUNCE_CYCLES low cycles, keyHeld falls, the FSM enters SCAN at the next row, and the dwell counter is 0.
REQ-026 keyValid and multiKey SHALL never assert in the same cycle.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While reset=0 at a rising edge: rows=one-hot row 0, state SCAN, keyValid=0, keyCode=0, keyHeld=0, multiKey=0, all counters and synchroniser flops 0.
REQ-029 Reset asserted in any state, including mid-HELD, SHALL take effect on the next edge with no pending pulse emitted afterwards.

Structure
REQ-030 Package keyscan_pkg SHALL hold the state enum and the default parameter constants.
REQ-031 The synchroniser SHALL be sub-module sync_2ff, parametrised by width.

Verification
REQ-032 Default params; cols[1] high, in sync with rows[2] and held 50 cycles -> exactly one keyValid, keyCode=9, keyHeld high until 8 low cycles after release.
REQ-033 cols[0] high 5 cycles during a row-0 dwell, then low -> no keyValid; scanning resumes at row 1.
REQ-034 cols[1] and cols[3] high together on a row sample -> one multiKey pulse per sample, no keyValid, rows keep rotating 0001->0010->0100->1000->0001.
REQ-035 REPEAT_CYCLES=20, key (row 3, col 3) held 100 cycles after acceptance -> keyValid pulses 20 cycles apart, keyCode=15 each time.
REQ-036 Release glitch: in RELEASE the column returns high after 4 low cycles -> back to HELD, keyHeld stays 1, no extra keyValid.
REQ-037 reset=0 asserted mid-HELD -> next edge rows=0001, keyHeld=0, keyCode=0; no keyValid after reset deasserts until a new full debounce completes.
